// File: rtl/reorder_pkg.sv
// Shared types and constants for the symbol reorder block.
// The optional error counter is enabled by defining REORDER_ERR_CNT_EN.
package reorder_pkg;

  typedef enum logic [1:0] {
    MODE_PASS      = 2'd0,
    MODE_CHUNK_REV = 2'd1,
    MODE_BIT_REV   = 2'd2,
    MODE_RSVD      = 2'd3
  } mode_e;

  // Width of the saturating truncation-error counter.
  localparam int ERR_CNT_W = 16;

  // The reserved mode behaves as pass-through, so fold it away at latch time.
  function automatic mode_e effective_mode(input logic [1:0] raw);
    mode_e m;
    m = mode_e'(raw);
    return (m == MODE_RSVD) ? MODE_PASS : m;
  endfunction

endpackage

// File: rtl/reorder_sym_buf.sv
// One ping-pong symbol buffer: beats are written by index, and beats are
// read back by index after the selected permutation. The read sees the beat
// being written in the same cycle, so the first output beat can be produced
// while the last input beat is still arriving.
module reorder_sym_buf
  import reorder_pkg::*;
#(
  parameter int CHUNK_W = 2,
  parameter int SYM_W   = 8,
  parameter int IDX_W   = $clog2(SYM_W / CHUNK_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_W-1:0]   widx,
  input  logic [CHUNK_W-1:0] wdata,
  input  mode_e              rmode,
  input  logic [IDX_W-1:0]   ridx,
  output logic [CHUNK_W-1:0] rdata
);

  localparam int N = SYM_W / CHUNK_W;

  logic [SYM_W-1:0] sym;
  logic [SYM_W-1:0] sym_next;
  logic [SYM_W-1:0] sym_rev;

  // Merge the incoming beat into the stored symbol.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned and infers a latch.
    sym_next = sym;
    if (we) begin
      sym_next[int'(widx)*CHUNK_W +: CHUNK_W] = wdata;
    end
  end

  // Hold the symbol; it is a small flop bank, so it is cleared on reset.
  always_ff @(posedge clk) begin
    // NOTE: a flop-based buffer can take a reset; a RAM-based one could not, and would need valid tracking instead.
    if (!rst) begin
      sym <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sym <= sym_next;
    end
  end

  // Select the requested output beat through the active permutation.
  always_comb begin
    sym_rev = '0;
    for (int i = 0; i < SYM_W; i++) begin
      sym_rev[i] = sym_next[SYM_W-1-i];
    end
    rdata = '0;
    case (rmode)
      MODE_CHUNK_REV: rdata = sym_next[(N-1-int'(ridx))*CHUNK_W +: CHUNK_W];
      MODE_BIT_REV:   rdata = sym_rev[int'(ridx)*CHUNK_W +: CHUNK_W];
      default:        rdata = sym_next[int'(ridx)*CHUNK_W +: CHUNK_W];
    endcase
  end

endmodule

// File: rtl/symbol_reorder.sv
// Symbol reorder: gathers CHUNK_W-bit beats into SYM_W-bit symbols in two
// ping-pong buffers and re-emits each symbol passed through, chunk-reversed
// or bit-reversed. Define REORDER_ERR_CNT_EN to add the err_cnt output.
module symbol_reorder
  import reorder_pkg::*;
#(
  parameter int CHUNK_W = 2,
  parameter int SYM_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               axiiv,
  input  logic [CHUNK_W-1:0] axiid,
  input  logic [1:0]         mode,
  output logic               axiov,
  output logic [CHUNK_W-1:0] axiod,
  output logic               frame_err
`ifdef REORDER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int N     = SYM_W / CHUNK_W;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic               axiiv_q;
  mode_e              mode_q;
  logic [IDX_W-1:0]   beat_cnt;
  logic               wr_sel;

  logic               draining;
  logic [IDX_W-1:0]   drain_cnt;
  logic               rd_sel;
  mode_e              drain_mode;

  logic               first_beat;
  logic               complete;
  mode_e              cur_mode;
  logic [IDX_W-1:0]   rd_idx;
  mode_e              rd_mode;
  logic               src_sel;
  logic [CHUNK_W-1:0] rdata0;
  logic [CHUNK_W-1:0] rdata1;
  logic [CHUNK_W-1:0] beat_out;

  assign first_beat = axiiv && !axiiv_q;
  assign cur_mode   = first_beat ? effective_mode(mode) : mode_q;
  assign complete   = axiiv && (beat_cnt == LAST_IDX);

  // A completing symbol emits its beat 0 from the write buffer; otherwise
  // the in-flight drain reads the other buffer. The two never overlap.
  assign rd_idx   = complete ? '0 : drain_cnt;
  assign rd_mode  = complete ? cur_mode : drain_mode;
  assign src_sel  = complete ? wr_sel : rd_sel;
  assign beat_out = src_sel ? rdata1 : rdata0;

  reorder_sym_buf #(.CHUNK_W(CHUNK_W), .SYM_W(SYM_W), .IDX_W(IDX_W)) u_buf0 (
    .clk   (clk),
    .rst   (rst),
    .we    (axiiv && !wr_sel),
    .widx  (beat_cnt),
    .wdata (axiid),
    .rmode (rd_mode),
    .ridx  (rd_idx),
    .rdata (rdata0)
  );

  reorder_sym_buf #(.CHUNK_W(CHUNK_W), .SYM_W(SYM_W), .IDX_W(IDX_W)) u_buf1 (
    .clk   (clk),
    .rst   (rst),
    .we    (axiiv && wr_sel),
    .widx  (beat_cnt),
    .wdata (axiid),
    .rmode (rd_mode),
    .ridx  (rd_idx),
    .rdata (rdata1)
  );

  // Input side: latch the frame mode, count beats, swap buffers, flag truncation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      axiiv_q   <= 1'b0;
      mode_q    <= MODE_PASS;
      beat_cnt  <= '0;
      wr_sel    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      axiiv_q   <= axiiv;
      frame_err <= 1'b0;
      if (first_beat) begin
        mode_q <= effective_mode(mode);
      end
      if (axiiv) begin
        if (complete) begin
          beat_cnt <= '0;
          wr_sel   <= ~wr_sel;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end else if (beat_cnt != '0) begin
        // The frame ended mid-symbol: drop the partial beats.
        beat_cnt  <= '0;
        frame_err <= 1'b1;
      end
    end
  end

  // Output side: drain a completed symbol over N consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      axiov      <= 1'b0;
      axiod      <= '0;
      draining   <= 1'b0;
      drain_cnt  <= '0;
      rd_sel     <= 1'b0;
      drain_mode <= MODE_PASS;
    end else if (complete) begin
      axiov      <= 1'b1;
      axiod      <= beat_out;
      draining   <= 1'b1;
      drain_cnt  <= IDX_W'(1);
      rd_sel     <= wr_sel;
      drain_mode <= cur_mode;
    end else if (draining) begin
      axiov <= 1'b1;
      axiod <= beat_out;
      if (drain_cnt == LAST_IDX) begin
        draining  <= 1'b0;
        drain_cnt <= '0;
      end else begin
        drain_cnt <= drain_cnt + 1'b1;
      end
    end else begin
      axiov <= 1'b0;
    end
  end

`ifdef REORDER_ERR_CNT_EN
  // Saturating count of truncation errors.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (frame_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_symbol_reorder.sv
// Directed self-checking bench for symbol_reorder (CHUNK_W=2, SYM_W=8).
// Define REORDER_ERR_CNT_EN to also exercise the error counter.
module tb_symbol_reorder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       axiiv = 1'b0;
  logic [1:0] axiid = 2'b00;
  logic [1:0] mode = 2'b00;
  logic       axiov;
  logic [1:0] axiod;
  logic       frame_err;
`ifdef REORDER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  symbol_reorder #(.CHUNK_W(2), .SYM_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .axiiv     (axiiv),
    .axiid     (axiid),
    .mode      (mode),
    .axiov     (axiov),
    .axiod     (axiod),
    .frame_err (frame_err)
`ifdef REORDER_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated symbol: mode m on beat 0, m_late on later beats (must be ignored).
  task automatic run_symbol(input string tag, input logic [7:0] din, input logic [1:0] m,
                            input logic [1:0] m_late, input logic [7:0] dexp);
    for (int k = 0; k < 4; k++) begin
      axiiv = 1'b1;
      axiid = din[k*2 +: 2];
      mode  = (k == 0) ? m : m_late;
      step();
      n_cmp++;
      if (frame_err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s in%0d frame_err: got %b want 0", tag, k, frame_err);
      end
      if (k < 3) begin
        n_cmp++;
        if (axiov !== 1'b0) begin
          n_bad++;
          $display("FAIL %s in%0d axiov: got %b want 0", tag, k, axiov);
        end
      end
    end
    axiiv = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      n_cmp++;
      if (axiov !== 1'b1 || axiod !== dexp[j*2 +: 2] || frame_err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s out%0d: got v=%b d=%b e=%b want v=1 d=%b e=0",
                 tag, j, axiov, axiod, frame_err, dexp[j*2 +: 2]);
      end
    end
    step();
    n_cmp++;
    if (axiov !== 1'b0 || axiod !== dexp[7:6] || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle: got v=%b d=%b e=%b want v=0 d=%b e=0",
               tag, axiov, axiod, frame_err, dexp[7:6]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (axiov !== 1'b0 || axiod !== 2'b00 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got v=%b d=%b e=%b want 0 00 0", axiov, axiod, frame_err);
    end
`ifdef REORDER_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset err_cnt: got %0d want 0", err_cnt);
    end
`endif
    rst = 1'b1;
    step();
  endtask

  task automatic test_pass();
    run_symbol("pass", 8'hB4, 2'd0, 2'd1, 8'hB4);
  endtask

  task automatic test_chunk_rev();
    run_symbol("chunk_rev", 8'hB4, 2'd1, 2'd2, 8'h1E);
  endtask

  task automatic test_bit_rev();
    run_symbol("bit_rev", 8'hB4, 2'd2, 2'd0, 8'h2D);
  endtask

  task automatic test_reserved();
    run_symbol("reserved", 8'hB4, 2'd3, 2'd1, 8'hB4);
  endtask

  // Three gap-free bytes: output stream equals input stream, three cycles later.
  task automatic test_back_to_back();
    logic [23:0] stream;
    stream = 24'h563412;
    for (int i = 0; i < 16; i++) begin
      if (i < 12) begin
        axiiv = 1'b1;
        axiid = stream[i*2 +: 2];
        mode  = 2'd0;
      end else begin
        axiiv = 1'b0;
      end
      step();
      if (i >= 3 && i < 15) begin
        n_cmp++;
        if (axiov !== 1'b1 || axiod !== stream[(i-3)*2 +: 2]) begin
          n_bad++;
          $display("FAIL b2b beat%0d: got v=%b d=%b want v=1 d=%b",
                   i - 3, axiov, axiod, stream[(i-3)*2 +: 2]);
        end
      end else begin
        n_cmp++;
        if (axiov !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b step%0d axiov: got %b want 0", i, axiov);
        end
      end
    end
  endtask

  // 0xB4 then two beats of 0x12 and a fall: 0xB4 drains intact, one error pulse.
  task automatic test_truncation();
    logic [11:0] beats;
    logic [7:0]  dexp;
    int          pulses;
    beats  = 12'b00_10_10_11_01_00;
    dexp   = 8'hB4;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        axiiv = 1'b1;
        axiid = beats[i*2 +: 2];
        mode  = 2'd0;
      end else begin
        axiiv = 1'b0;
      end
      step();
      if (frame_err === 1'b1) pulses++;
      if (i >= 3 && i <= 6) begin
        n_cmp++;
        if (axiov !== 1'b1 || axiod !== dexp[(i-3)*2 +: 2]) begin
          n_bad++;
          $display("FAIL trunc drain%0d: got v=%b d=%b want v=1 d=%b",
                   i - 3, axiov, axiod, dexp[(i-3)*2 +: 2]);
        end
      end else if (i > 6) begin
        n_cmp++;
        if (axiov !== 1'b0) begin
          n_bad++;
          $display("FAIL trunc step%0d axiov: got %b want 0", i, axiov);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (frame_err !== 1'b1) begin
          n_bad++;
          $display("FAIL trunc err_timing: got %b want 1", frame_err);
        end
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL trunc pulses: got %0d want 1", pulses);
    end
`ifdef REORDER_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL trunc err_cnt: got %0d want 1", err_cnt);
    end
`endif
    run_symbol("after_trunc", 8'h34, 2'd1, 2'd1, 8'h1C);
  endtask

  // Reset during drain beat 2, then a clean bit-reverse frame.
  task automatic test_reset_mid_drain();
    for (int k = 0; k < 4; k++) begin
      axiiv = 1'b1;
      axiid = 8'hB4 >> (k * 2);
      mode  = 2'd0;
      step();
    end
    axiiv = 1'b0;
    step();
    n_cmp++;
    if (axiov !== 1'b1 || axiod !== 2'b01) begin
      n_bad++;
      $display("FAIL mid_drain beat1: got v=%b d=%b want v=1 d=01", axiov, axiod);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (axiov !== 1'b0 || axiod !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_drain in_reset: got v=%b d=%b want v=0 d=00", axiov, axiod);
    end
`ifdef REORDER_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_drain err_cnt: got %0d want 0", err_cnt);
    end
`endif
    rst = 1'b1;
    step();
    n_cmp++;
    if (axiov !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_drain release: got v=%b want 0", axiov);
    end
    run_symbol("after_reset", 8'hB4, 2'd2, 2'd2, 8'h2D);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_chunk_rev();
    test_bit_rev();
    test_reserved();
    test_back_to_back();
    test_truncation();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/symbol_reorder.md
SYMBOL_REORDER -- requirements
Module: symbol_reorder

Interface
REQ-001 SHALL have parameter CHUNK_W, default 2, meaning bits per input/output beat.
REQ-002 SHALL have parameter SYM_W, default 8, meaning bits per symbol; SYM_W % CHUNK_W == 0 and N = SYM_W/CHUNK_W >= 2.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port axiiv  input  1  input beat valid; a contiguous high run is one frame.
REQ-006 SHALL have port axiid  input  CHUNK_W  input beat data; beat k of a symbol carries symbol bits [k*CHUNK_W +: CHUNK_W].
REQ-007 SHALL have port mode  input  2  reorder mode: 0 pass, 1 chunk-reverse, 2 bit-reverse, 3 reserved.
REQ-008 SHALL have port axiov  output  1  output beat valid.
REQ-009 SHALL have port axiod  output  CHUNK_W  output beat data.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a truncated symbol.

Function
REQ-011 SHALL latch mode on the first beat of each frame (axiiv high, previous cycle low) and hold it for the whole frame.
REQ-012 SHALL collect N beats per symbol into one of two ping-pong symbol buffers, then switch buffers.
REQ-013 SHALL, when beat N-1 of a symbol is accepted at cycle t, emit that symbol's N output beats on cycles t+1..t+N with axiov high.
REQ-014 SHALL, for mode 0, emit output beat j = symbol bits [j*CHUNK_W +: CHUNK_W].
REQ-015 SHALL, for mode 1, emit output beat j = symbol chunk N-1-j (chunk order reversed, bits within each chunk unchanged).
REQ-016 SHALL, for mode 2, bit-reverse the whole symbol (bit i -> bit SYM_W-1-i), then emit beats as in mode 0.
REQ-017 SHALL treat mode 3 exactly as mode 0.
REQ-018 SHALL produce gap-free output for gap-free input: the next symbol's first beat follows the previous symbol's last beat on consecutive cycles.
REQ-019 SHALL drive axiov low and hold axiod at its last value whenever no complete symbol is draining.
REQ-020 SHALL, on an axiiv fall with 0 < beat count < N, discard the partial symbol, reset the beat count to 0, and pulse frame_err on the following cycle.
REQ-021 SHALL finish draining a complete symbol that is already in flight when a truncation or new frame occurs; no output beat is lost or duplicated.
REQ-022 SHALL, on an axiiv fall with beat count == 0, raise no error.

Reset
REQ-023 SHALL, while rst is low, set axiov=0, axiod=0, frame_err=0, beat count=0, drain count=0, buffer select=0, both buffers=0 and latched mode=0.
REQ-024 SHALL, on reset asserted mid-frame or mid-drain, abandon all in-flight data; the first cycle after release SHALL show axiov=0.

Configuration
REQ-025 SHALL, when REORDER_ERR_CNT_EN is defined, add output err_cnt (16 bits) that increments on each frame_err pulse, saturates at 0xFFFF and resets to 0.
REQ-026 SHALL, when REORDER_ERR_CNT_EN is undefined, have no err_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-027 SHALL import reorder_pkg, which holds the mode enum typedef (MODE_PASS, MODE_CHUNK_REV, MODE_BIT_REV, MODE_RSVD) and the saturating counter width constant.
REQ-028 SHALL put each ping-pong buffer in sub-module reorder_sym_buf (beat write by index, mode-permuted beat read by index), instantiated twice.

Verification (CHUNK_W=2, SYM_W=8)
REQ-029 SHALL cover: byte 0xB4 as beats 00,01,11,10 with mode 0 -> output 00,01,11,10 on cycles t+1..t+4.
REQ-030 SHALL cover: same input with mode 1 -> output 10,11,01,00.
REQ-031 SHALL cover: same input with mode 2 -> output 01,11,10,00 (0x2D).
REQ-032 SHALL cover: 3 back-to-back bytes 0x12,0x34,0x56 in mode 0 -> 12 contiguous output beats with no axiov gap.
REQ-033 SHALL cover: 0xB4 followed by 2 beats of a second byte, then axiiv low -> 0xB4 drains fully, frame_err pulses once, err_cnt=1 with the macro defined.
REQ-034 SHALL cover: rst low during beat 2 of a drain -> axiov=0 next cycle, and a subsequent clean frame reorders correctly.
